pipe_stage_reg: RTL and testbench

//  Generic, parametrised pipeline stage register for the pipelined CPU.

---
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle between two pipeline stages: valid, ready, ctrl, data.
// master drives valid/ctrl/data and samples ready; slave does the reverse.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 256
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and a
// saturating bubble counter. Ports: clk, reset (async, active-high),
// up (slave: in_valid/in_ready/in_ctrl/in_data), dn (master:
// out_valid/out_ready/out_ctrl/out_data), flush, bubble_cnt.
// Define PIPE_SKID_EN for a 2-entry skid buffer with registered in_ready;
// otherwise a single entry with combinational in_ready.
module pipe_stage_reg #(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 256,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              emit;

  assign dn.valid = valid_q;
  assign dn.ctrl  = ctrl_q;
  assign dn.data  = data_q;
  assign accept   = up.valid & up.ready;
  assign emit     = valid_q & dn.ready;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t            state;
  logic              rdy_q;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign up.ready = rdy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      rdy_q     <= 1'b1;
      valid_q   <= 1'b0;
      ctrl_q    <= NOP_CTRL;
      data_q    <= '0;
      skid_ctrl <= NOP_CTRL;
      skid_data <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      rdy_q   <= 1'b1;
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state   <= ONE;
            valid_q <= 1'b1;
            ctrl_q  <= up.ctrl;
            data_q  <= up.data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            ctrl_q <= up.ctrl;
            data_q <= up.data;
          end else if (accept) begin
            // Downstream stalled: park the new word behind the head.
            state     <= FULL;
            rdy_q     <= 1'b0;
            skid_ctrl <= up.ctrl;
            skid_data <= up.data;
          end else if (emit) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ctrl_q  <= NOP_CTRL;
          end
        end
        FULL: begin
          if (emit) begin
            state  <= ONE;
            rdy_q  <= 1'b1;
            ctrl_q <= skid_ctrl;
            data_q <= skid_data;
          end
        end
        default: begin
          state   <= EMPTY;
          rdy_q   <= 1'b1;
          valid_q <= 1'b0;
          ctrl_q  <= NOP_CTRL;
        end
      endcase
    end
  end
`else
  assign up.ready = ~valid_q | dn.ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= up.ctrl;
      data_q  <= up.data;
    end else if (emit) begin
      // data_q is left as-is to avoid needless toggling.
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (dn.ready && !valid_q && !(&bubble_cnt)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int MAXCNT = (1 << NW) - 1;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [NW-1:0] bubble_cnt;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn ();

  pipe_stage_reg #(
    .CTRL_W  (CW),
    .DATA_W  (DW),
    .NOP_CTRL(16'h0000),
    .CNT_W   (NW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .up        (up),
    .dn        (dn),
    .flush     (flush),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  typedef struct {
    bit            iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    bit            ordy;
    bit            fl;
    bit            ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
  } vec_t;

  word_t         q[$];
  logic [DW-1:0] last_d;
  int            bub;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic bit model_rdy(input bit ordy);
    if (DEPTH == 2) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  task automatic model_clear();
    q.delete();
    last_d = '0;
    bub = 0;
  endtask

  // One clock: drive at negedge, check, clock edge, update model.
  task automatic step(input bit iv, input logic [CW-1:0] ic,
                      input logic [DW-1:0] id, input bit ordy,
                      input bit fl);
    bit    rdy, vld, acc, emt;
    word_t w;
    up.valid = iv;
    up.ctrl  = ic;
    up.data  = id;
    dn.ready = ordy;
    flush    = fl;
    #1;
    rdy = model_rdy(ordy);
    vld = q.size() > 0;
    chk("in_ready", up.ready, rdy);
    chk("out_valid", dn.valid, vld);
    chk("out_ctrl", dn.ctrl, vld ? q[0].c : 16'h0000);
    chk("out_data", dn.data, last_d);
    chk("bubble_cnt", bubble_cnt, bub);
    @(posedge clk);
    acc = iv && rdy;
    emt = vld && ordy;
    if (ordy && !vld && bub < MAXCNT) bub++;
    if (fl) begin
      q.delete();
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) begin
        w.c = ic;
        w.d = id;
        q.push_back(w);
      end
    end
    if (q.size() > 0) last_d = q[0].d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    up.valid = 1'b0;
    dn.ready = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    up.valid = 1'b0;
    up.ctrl  = '0;
    up.data  = '0;
    dn.ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Reset values.
    #1;
    chk("rst_valid", dn.valid, 0);
    chk("rst_ctrl", dn.ctrl, 0);
    chk("rst_data", dn.data, 0);
    chk("rst_bub", bubble_cnt, 0);
    chk("rst_ready", up.ready, 1);

    // Vector table: streaming, ctrl gating, flush, flush while empty.
    for (int i = 1; i <= 8; i++) begin
      v = '{1, 16'h0100 | 16'(i), 32'(i), 1, 0, 1, 16'h0100 | 16'(i),
            32'(i)};
      vecs.push_back(v);
    end
    vecs.push_back('{0, 16'hFFFF, 32'hDEAD, 1, 0, 0, 16'h0, 32'd8});
    vecs.push_back('{0, 16'hFFFF, 32'hBEEF, 1, 0, 0, 16'h0, 32'd8});
    vecs.push_back('{1, 16'h0011, 32'h11, 1, 0, 1, 16'h0011, 32'h11});
    vecs.push_back('{1, 16'h0077, 32'h77, 1, 1, 0, 16'h0, 32'h11});
    vecs.push_back('{0, 16'h0077, 32'h77, 1, 1, 0, 16'h0, 32'h11});
    vecs.push_back('{1, 16'h0022, 32'h22, 0, 0, 1, 16'h0022, 32'h22});
    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      #1;
      chk($sformatf("vec%0d_valid", i), dn.valid, vecs[i].ev);
      chk($sformatf("vec%0d_ctrl", i), dn.ctrl, vecs[i].ec);
      chk($sformatf("vec%0d_data", i), dn.data, vecs[i].ed);
    end

    // Reset asserted mid-cycle while holding a word.
    #2;
    reset = 1'b1;
    #1;
    chk("t1_valid", dn.valid, 0);
    chk("t1_ctrl", dn.ctrl, 0);
    chk("t1_bub", bubble_cnt, 0);
    chk("t1_data", dn.data, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Stall: A5 held three cycles; skid also takes B6.
    step(1, 16'h00A5, 32'hA5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h00B6, 32'hB6, 0, 0);
      #1;
      chk("t3_hold", dn.data, 32'hA5);
      chk("t3_hold_v", dn.valid, 1);
    end
    step(DEPTH == 1, 16'h00B6, 32'hB6, 1, 0);
    #1;
    chk("t3_second", dn.data, 32'hB6);
    chk("t3_second_v", dn.valid, 1);
    step(0, 16'h0, 32'h0, 1, 0);
    #1;
    chk("t3_drained", dn.valid, 0);

    // Bubble counter saturates at 15 and holds.
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 16'hFFFF, 32'h0, 1, 0);
    #1;
    chk("t5_sat", bubble_cnt, 4'd15);
    chk("t6_ctrl", dn.ctrl, 16'h0000);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
